// File: rtl/axi_pkg.sv
// Shared types and widths for the two-requester AXI-lite style request arbiter.
package axi_pkg;

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DATA_W = 4;
   localparam int unsigned NREQ   = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ADDR,
      ST_RD_DATA,
      ST_WR,
      ST_DONE
   } state_e;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } txn_t;

   function automatic logic [NREQ-1:0] idx2onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the requester not granted last wins.
module rr_arb2 (
   input  logic [1:0] req_i,
   input  logic       last_i,
   input  logic       upd_i,
   output logic [1:0] gnt_c
);

   always_comb begin
      gnt_c = 2'b00;
      if (upd_i) begin
         case (req_i)
            2'b01:   gnt_c = 2'b01;
            2'b10:   gnt_c = 2'b10;
            2'b11:   gnt_c = last_i ? 2'b01 : 2'b10;
            default: gnt_c = 2'b00;
         endcase
      end
   end

endmodule

// File: rtl/axi_req_arbiter.sv
// Arbitrates two requesters onto a single AXI-lite style master port with a
// per-phase slave-wait timeout. All outputs come straight from flops.
module axi_req_arbiter
   import axi_pkg::*;
#(
   parameter int unsigned TO_CYCLES = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          we,
   input  logic [NREQ*ADDR_W-1:0]   addr,
   input  logic [NREQ*DATA_W-1:0]   wdata,
   output logic [NREQ-1:0]          done,
   output logic                     err,
   output logic [DATA_W-1:0]        rdata,
   output logic                     ms_arvalid,
   output logic [ADDR_W-1:0]        ms_araddr,
   input  logic                     sm_arready,
   output logic                     ms_rready,
   input  logic                     sm_rvalid,
   input  logic [DATA_W-1:0]        sm_rdata,
   output logic                     ms_awvalid,
   output logic [ADDR_W-1:0]        ms_awaddr,
   input  logic                     sm_awready,
   output logic                     ms_wvalid,
   output logic [DATA_W-1:0]        ms_wdata,
   input  logic                     sm_wready
);

   localparam int unsigned CNT_W = $clog2(TO_CYCLES + 2);

   state_e            state_q, state_d;
   txn_t              txn_q, txn_d;
   logic              gnt_q, gnt_d;
   logic              last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              arvalid_q, arvalid_d;
   logic              rready_q, rready_d;
   logic              awvalid_q, awvalid_d;
   logic              wvalid_q, wvalid_d;
   logic [NREQ-1:0]   done_q, done_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic [1:0]        gnt_c;
   logic [CNT_W-1:0]  cnt_inc;
   logic              to_hit;

   assign cnt_inc = cnt_q + CNT_W'(1);
   assign to_hit  = (TO_CYCLES != 0) && (32'(cnt_inc) == TO_CYCLES);

   rr_arb2 u_arb (
      .req_i  (req),
      .last_i (last_q),
      .upd_i  (state_q == ST_IDLE),
      .gnt_c  (gnt_c)
   );

   // Next-state and registered-output decode
   always_comb begin
      state_d   = state_q;
      txn_d     = txn_q;
      gnt_d     = gnt_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      done_d    = '0;
      err_d     = 1'b0;
      rdata_d   = rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (|gnt_c) begin
               gnt_d       = gnt_c[1];
               last_d      = gnt_c[1];
               txn_d.we    = we[gnt_c[1]];
               txn_d.addr  = gnt_c[1] ? addr[2*ADDR_W-1:ADDR_W]   : addr[ADDR_W-1:0];
               txn_d.wdata = gnt_c[1] ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
               cnt_d       = '0;
               if (we[gnt_c[1]]) begin
                  state_d   = ST_WR;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = ST_RD_ADDR;
                  arvalid_d = 1'b1;
               end
            end
         end
         ST_RD_ADDR: begin
            if (sm_arready) begin
               state_d  = ST_RD_DATA;
               rready_d = 1'b1;
               cnt_d    = '0;
            end else if (to_hit) begin
               state_d = ST_DONE;
               done_d  = idx2onehot(gnt_q);
               err_d   = 1'b1;
            end else begin
               arvalid_d = 1'b1;
               cnt_d     = cnt_inc;
            end
         end
         ST_RD_DATA: begin
            if (sm_rvalid) begin
               if (!txn_q.we) rdata_d = sm_rdata;
               state_d = ST_DONE;
               done_d  = idx2onehot(gnt_q);
            end else if (to_hit) begin
               state_d = ST_DONE;
               done_d  = idx2onehot(gnt_q);
               err_d   = 1'b1;
            end else begin
               rready_d = 1'b1;
               cnt_d    = cnt_inc;
            end
         end
         ST_WR: begin
            // each valid falls the cycle after its own handshake
            awvalid_d = awvalid_q & ~sm_awready;
            wvalid_d  = wvalid_q & ~sm_wready;
            if (!awvalid_q && !wvalid_q) begin
               state_d = ST_DONE;
               done_d  = idx2onehot(gnt_q);
            end else if (to_hit && (awvalid_d || wvalid_d)) begin
               state_d   = ST_DONE;
               done_d    = idx2onehot(gnt_q);
               err_d     = 1'b1;
               awvalid_d = 1'b0;
               wvalid_d  = 1'b0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         txn_q     <= '0;
         gnt_q     <= 1'b0;
         last_q    <= 1'b1;
         cnt_q     <= '0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         done_q    <= '0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         txn_q     <= txn_d;
         gnt_q     <= gnt_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         done_q    <= done_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
      end
   end

   assign done       = done_q;
   assign err        = err_q;
   assign rdata      = rdata_q;
   assign ms_arvalid = arvalid_q;
   assign ms_araddr  = txn_q.addr;
   assign ms_rready  = rready_q;
   assign ms_awvalid = awvalid_q;
   assign ms_awaddr  = txn_q.addr;
   assign ms_wvalid  = wvalid_q;
   assign ms_wdata   = txn_q.wdata;

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Directed bench for axi_req_arbiter: arbitration, read/write handshakes,
// timeout and mid-transaction reset, with hand-computed expectations.
module tb_axi_req_arbiter;

   logic       clk;
   logic       rst_n;
   logic [1:0] req, we;
   logic [7:0] addr, wdata;
   logic [1:0] done;
   logic       err;
   logic [3:0] rdata;
   logic       ms_arvalid, sm_arready, ms_rready, sm_rvalid;
   logic       ms_awvalid, sm_awready, ms_wvalid, sm_wready;
   logic [3:0] ms_araddr, sm_rdata, ms_awaddr, ms_wdata;

   int         n_cmp = 0;
   int         n_err = 0;
   int         cyc;
   logic [3:0] aw_q[$];
   logic [3:0] w_q[$];
   logic [3:0] a0, a1, d0, d1;

   axi_req_arbiter #(.TO_CYCLES(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .we         (we),
      .addr       (addr),
      .wdata      (wdata),
      .done       (done),
      .err        (err),
      .rdata      (rdata),
      .ms_arvalid (ms_arvalid),
      .ms_araddr  (ms_araddr),
      .sm_arready (sm_arready),
      .ms_rready  (ms_rready),
      .sm_rvalid  (sm_rvalid),
      .sm_rdata   (sm_rdata),
      .ms_awvalid (ms_awvalid),
      .ms_awaddr  (ms_awaddr),
      .sm_awready (sm_awready),
      .ms_wvalid  (ms_wvalid),
      .ms_wdata   (ms_wdata),
      .sm_wready  (sm_wready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // record what the slave actually accepts on the write channels
   always @(posedge clk) begin
      if (rst_n && ms_awvalid && sm_awready) aw_q.push_back(ms_awaddr);
      if (rst_n && ms_wvalid && sm_wready)   w_q.push_back(ms_wdata);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   initial begin
      rst_n = 1'b0; req = 2'b00; we = 2'b00; addr = 8'h00; wdata = 8'h00;
      sm_arready = 1'b0; sm_rvalid = 1'b0; sm_rdata = 4'h0;
      sm_awready = 1'b0; sm_wready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_done",    32'(done), 32'h0);
      check("rst_err",     32'(err), 32'h0);
      check("rst_rdata",   32'(rdata), 32'h0);
      check("rst_arvalid", 32'(ms_arvalid), 32'h0);
      check("rst_rready",  32'(ms_rready), 32'h0);
      check("rst_awvalid", 32'(ms_awvalid), 32'h0);
      check("rst_wvalid",  32'(ms_wvalid), 32'h0);
      check("rst_araddr",  32'(ms_araddr), 32'h0);
      rst_n = 1'b1;
      aw_q.delete();
      w_q.delete();

      // simultaneous writes: requester 0 wins the first tie
      sm_arready = 1'b1; sm_rvalid = 1'b1; sm_awready = 1'b1; sm_wready = 1'b1;
      req = 2'b11; we = 2'b11; addr = 8'h21; wdata = 8'h95;
      tick;
      check("tw_awvalid0", 32'(ms_awvalid), 32'h1);
      check("tw_wvalid0",  32'(ms_wvalid), 32'h1);
      check("tw_awaddr0",  32'(ms_awaddr), 32'h1);
      check("tw_wdata0",   32'(ms_wdata), 32'h5);
      tick;
      check("tw_awdrop0",  32'(ms_awvalid), 32'h0);
      check("tw_wdrop0",   32'(ms_wvalid), 32'h0);
      tick;
      check("tw_done0",    32'(done), 32'h1);
      check("tw_err0",     32'(err), 32'h0);
      req = 2'b10;
      tick;
      check("tw_idle",     32'(done), 32'h0);
      tick;
      check("tw_awvalid1", 32'(ms_awvalid), 32'h1);
      check("tw_awaddr1",  32'(ms_awaddr), 32'h2);
      check("tw_wdata1",   32'(ms_wdata), 32'h9);
      tick;
      tick;
      check("tw_done1",    32'(done), 32'h2);
      req = 2'b00; we = 2'b00;
      tick;
      check("tw_aw_count", 32'(aw_q.size()), 32'h2);
      check("tw_w_count",  32'(w_q.size()), 32'h2);
      a0 = (aw_q.size() > 0) ? aw_q[0] : 4'hF;
      a1 = (aw_q.size() > 1) ? aw_q[1] : 4'hF;
      d0 = (w_q.size() > 0)  ? w_q[0]  : 4'hF;
      d1 = (w_q.size() > 1)  ? w_q[1]  : 4'hF;
      check("tw_pair0_addr", 32'(a0), 32'h1);
      check("tw_pair0_data", 32'(d0), 32'h5);
      check("tw_pair1_addr", 32'(a1), 32'h2);
      check("tw_pair1_data", 32'(d1), 32'h9);

      // single read by requester 0, always-ready slave
      sm_rdata = 4'hA;
      req = 2'b01; addr = 8'h03;
      tick;
      check("rd_arvalid",  32'(ms_arvalid), 32'h1);
      check("rd_araddr",   32'(ms_araddr), 32'h3);
      tick;
      check("rd_rready",   32'(ms_rready), 32'h1);
      check("rd_ardrop",   32'(ms_arvalid), 32'h0);
      tick;
      check("rd_done",     32'(done), 32'h1);
      check("rd_rdata",    32'(rdata), 32'hA);
      check("rd_err",      32'(err), 32'h0);
      req = 2'b00;
      tick;
      check("rd_pulse",    32'(done), 32'h0);

      // tie after requester 0 was served: requester 1 wins
      sm_rdata = 4'hB;
      req = 2'b11; addr = 8'h76;
      tick;
      check("tr_araddr1",  32'(ms_araddr), 32'h7);
      tick;
      tick;
      check("tr_done1",    32'(done), 32'h2);
      check("tr_rdata1",   32'(rdata), 32'hB);
      req = 2'b01;
      tick;
      tick;
      check("tr_araddr0",  32'(ms_araddr), 32'h6);
      tick;
      tick;
      check("tr_done0",    32'(done), 32'h1);
      req = 2'b00;
      tick;

      // write by requester 1 with wready two cycles behind awready
      sm_wready = 1'b0; sm_awready = 1'b1;
      req = 2'b10; we = 2'b10; addr = 8'hC0; wdata = 8'h30;
      tick;
      check("dw_awvalid",  32'(ms_awvalid), 32'h1);
      check("dw_wvalid",   32'(ms_wvalid), 32'h1);
      addr = 8'h50; wdata = 8'h70; we = 2'b00;
      tick;
      check("dw_awdrop",   32'(ms_awvalid), 32'h0);
      check("dw_whold1",   32'(ms_wvalid), 32'h1);
      check("dw_awaddr",   32'(ms_awaddr), 32'hC);
      check("dw_wdata",    32'(ms_wdata), 32'h3);
      tick;
      check("dw_whold2",   32'(ms_wvalid), 32'h1);
      check("dw_nodone",   32'(done), 32'h0);
      sm_wready = 1'b1;
      tick;
      check("dw_wdrop",    32'(ms_wvalid), 32'h0);
      check("dw_nodone2",  32'(done), 32'h0);
      tick;
      check("dw_done",     32'(done), 32'h2);
      check("dw_err",      32'(err), 32'h0);
      req = 2'b00;
      tick;
      check("dw_pulse",    32'(done), 32'h0);

      // read timeout: arready stuck low
      sm_arready = 1'b0; sm_rdata = 4'hE;
      req = 2'b01; addr = 8'h04;
      tick;
      check("to_arvalid",  32'(ms_arvalid), 32'h1);
      cyc = 1;
      while (done === 2'b00 && cyc < 40) begin
         tick;
         cyc++;
      end
      check("to_latency",  32'(cyc), 32'd17);
      check("to_done",     32'(done), 32'h1);
      check("to_err",      32'(err), 32'h1);
      check("to_rdata",    32'(rdata), 32'hB);
      check("to_arvalid0", 32'(ms_arvalid), 32'h0);
      check("to_rready0",  32'(ms_rready), 32'h0);
      req = 2'b00;
      tick;
      check("to_errclr",   32'(err), 32'h0);

      // reset asserted during RD_DATA
      sm_arready = 1'b1; sm_rvalid = 1'b0;
      req = 2'b01; addr = 8'h02;
      tick;
      tick;
      check("rs_rready",   32'(ms_rready), 32'h1);
      #3;
      rst_n = 1'b0;
      #1;
      check("rs_rready0",  32'(ms_rready), 32'h0);
      check("rs_arvalid0", 32'(ms_arvalid), 32'h0);
      check("rs_done0",    32'(done), 32'h0);
      check("rs_rdata0",   32'(rdata), 32'h0);
      sm_rvalid = 1'b1; sm_rdata = 4'h6;
      tick;
      rst_n = 1'b1;
      check("rs_idle",     32'(ms_arvalid), 32'h0);
      tick;
      check("rs_arvalid",  32'(ms_arvalid), 32'h1);
      check("rs_araddr",   32'(ms_araddr), 32'h2);
      tick;
      check("rs_rready1",  32'(ms_rready), 32'h1);
      tick;
      check("rs_done",     32'(done), 32'h1);
      check("rs_rdata",    32'(rdata), 32'h6);
      req = 2'b00;
      tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
